// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the mips_lsu load/store unit.
// Build option: MIPS_LSU_SUBWORD_EN enables byte/half accesses.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam int WORD_BYTES = 4;

  // Illegal size or lane alignment for a request; sub-word sizes are illegal
  // unless the sub-word path is built in.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
`ifdef MIPS_LSU_SUBWORD_EN
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
`endif
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Lane merge for sub-word stores and lane extract/extend for loads.
// Exists only when MIPS_LSU_SUBWORD_EN is defined.
`ifdef MIPS_LSU_SUBWORD_EN
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    byte_sel  = rword_i[{lane_i, 3'b000} +: 8];
    half_sel  = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    st_word_o = rword_i;
    ld_data_o = rword_i;
    case (size_i)
      SIZE_BYTE: begin
        st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        if (lane_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else           st_word_o[15:0]  = wdata_i[15:0];
        ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule
`endif

// File: rtl/mips_lsu.sv
// Load/store unit: initiator side of data_memory (MemRead/MemWrite, word bus).
// Build option: MIPS_LSU_SUBWORD_EN adds byte/half loads and read-modify-write stores.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam int CNT_W  = 2;

  lsu_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q, mem_read_q, mem_write_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, rsp_rdata_q;
  logic              req_err;

  assign req_err = req_bad(req_size, req_addr[LANE_W-1:0]);

`ifdef MIPS_LSU_SUBWORD_EN
  logic        we_q, signed_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, st_word, ld_data;

  mips_lsu_align u_align (
    .size_i    (size_q),
    .signed_i  (signed_q),
    .lane_i    (lane_q),
    .rword_i   (mem_read_data),
    .wdata_i   (wdata_q),
    .st_word_o (st_word),
    .ld_data_o (ld_data)
  );
`else
  logic [31:0] ld_data;
  logic        unused_signed;
  assign ld_data       = mem_read_data;
  assign unused_signed = req_signed;
`endif

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MIPS_LSU_SUBWORD_EN
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          req_ready_q <= 1'b0;
`ifdef MIPS_LSU_SUBWORD_EN
          we_q        <= req_we;
          signed_q    <= req_signed;
          size_q      <= req_size;
          lane_q      <= req_addr[LANE_W-1:0];
          wdata_q     <= req_wdata;
`endif
          if (req_err) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            mem_addr_q <= {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            if (req_we && req_size == SIZE_WORD) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a word read.
              state_q    <= READ;
              mem_read_q <= 1'b1;
              cnt_q      <= CNT_W'(MEM_RD_LAT - 1);
            end
          end
        end
        READ: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            mem_read_q <= 1'b0;
`ifdef MIPS_LSU_SUBWORD_EN
            if (we_q) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
              mem_wdata_q <= st_word;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= ld_data;
            end
`else
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_data;
`endif
          end
        end
        WRITE: begin
          mem_write_q <= 1'b0;
          mem_wdata_q <= '0;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          mem_addr_q  <= '0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

endmodule
